// File: rtl/smi_header_pkg.sv
// smi_header_pkg: shared state encoding, eofc width and eofc mask helper for the SMI header extractor
package smi_header_pkg;

  localparam int EofcWidth = 8;

  typedef enum logic [1:0] {
    ExtractIdle = 2'd0,
    ExtractCopy = 2'd1,
    ExtractTail = 2'd2
  } extractState_t;

  function automatic logic [EofcWidth-1:0] eofcMask(input int flitWidth);
    return EofcWidth'(2 * flitWidth - 1);
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// smi_skid_buffer: 2-entry ready/stop register buffer; outputs and stop come straight from flops
module smi_skid_buffer
  import smi_header_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inReady,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);

  logic             skidValid;
  logic [Width-1:0] skidData;
  logic             loadMain;

  assign loadMain = !outReady || !outStop;
  assign inStop   = skidValid;

  // occupancy: main refills from skid first, otherwise from the input; skid catches a flit while main is stalled
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      outReady  <= 1'b0;
      skidValid <= 1'b0;
    end else if (loadMain) begin
      outReady  <= skidValid || inReady;
      skidValid <= 1'b0;
    end else if (inReady && !skidValid) begin
      skidValid <= 1'b1;
    end
  end

  // payload registers are unreset; they are only meaningful while their valid bit is set
  always_ff @(posedge clk) begin
    if (loadMain) outData <= skidValid ? skidData : inData;
    else if (inReady && !skidValid) skidData <= inData;
  end

endmodule

// File: rtl/smi_header_extract_pf1.sv
// smi_header_extract_pf1: strips a HeadWidth-byte header off each SMI frame and realigns the payload to byte 0.
// Optional macro SMI_HEADER_EXTRACT_RUNT_CHECK_EN: runt first flits are dropped and flagged on runtDetect
// instead of being emitted as a zero-padded header.
module smi_header_extract_pf1
  import smi_header_pkg::*;
#(
  parameter int FlitWidth = 16,
  parameter int HeadWidth = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   smiInReady,
  input  logic [EofcWidth-1:0]   smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   headerReady,
  output logic [HeadWidth*8-1:0] headerData,
  input  logic                   headerStop,
  output logic                   smiOutReady,
  output logic [EofcWidth-1:0]   smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop,
  output logic                   runtDetect
);

  localparam int                   FlitSplit  = FlitWidth - HeadWidth;
  localparam logic [EofcWidth-1:0] EofcMask   = eofcMask(FlitWidth);
  localparam logic [EofcWidth-1:0] HeadE      = EofcWidth'(HeadWidth);
  localparam logic [EofcWidth-1:0] FlitSplitE = EofcWidth'(FlitSplit);

  extractState_t                     state;
  logic                              regReady;
  logic [EofcWidth-1:0]              regEofc;
  logic [FlitWidth*8-1:0]            regData;
  logic [FlitSplit*8-1:0]            carry;
  logic [EofcWidth-1:0]              storedEofc;
  logic                              hdrStop, payStop, hdrPush, outPush, consume;
  logic                              isRunt, runtDrop, needOut;
  logic [HeadWidth*8-1:0]            hdrData;
  logic [FlitWidth*8-1:0]            payRaw, payData;
  logic [EofcWidth-1:0]              payEofc;
  logic [(FlitWidth+1)*8-1:0]        payOut;

  assign smiInStop = regReady && !consume;
  assign {smiOutEofc, smiOutData} = payOut;

  // per-state consume/push decisions; a flit is consumed only when every buffer it feeds can take it
  always_comb begin
    isRunt = regEofc != '0 && regEofc < HeadE;
`ifdef SMI_HEADER_EXTRACT_RUNT_CHECK_EN
    runtDrop = isRunt;
`else
    runtDrop = 1'b0;
`endif
    needOut = regEofc > HeadE;
    consume = 1'b0;
    hdrPush = 1'b0;
    outPush = 1'b0;
    payEofc = '0;
    payRaw  = {{HeadWidth*8{1'b0}}, carry};
    case (state)
      ExtractIdle: begin
        consume = regReady && (runtDrop || (!hdrStop && !(needOut && payStop)));
        hdrPush = consume && !runtDrop;
        outPush = consume && needOut;
        payEofc = regEofc - HeadE;
        payRaw  = {{HeadWidth*8{1'b0}}, regData[FlitWidth*8-1:HeadWidth*8]};
      end
      ExtractCopy: begin
        consume = regReady && !payStop;
        outPush = consume;
        payEofc = (regEofc == '0 || needOut) ? '0 : FlitSplitE + regEofc;
        payRaw  = {regData[HeadWidth*8-1:0], carry};
      end
      default: begin
        outPush = !payStop;
        payEofc = storedEofc - HeadE;
      end
    endcase
    for (int i = 0; i < HeadWidth; i++)
      hdrData[i*8+:8] = (isRunt && EofcWidth'(i) >= regEofc) ? 8'h00 : regData[i*8+:8];
    for (int i = 0; i < FlitWidth; i++)
      payData[i*8+:8] = (payEofc != '0 && EofcWidth'(i) >= payEofc) ? 8'h00 : payRaw[i*8+:8];
  end

  // frame state, input-stage valid and runt pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= ExtractIdle;
      regReady <= 1'b0;
`ifdef SMI_HEADER_EXTRACT_RUNT_CHECK_EN
      runtDetect <= 1'b0;
`endif
    end else begin
      if (!smiInStop) regReady <= smiInReady;
      case (state)
        ExtractIdle: if (consume && regEofc == '0) state <= ExtractCopy;
        ExtractCopy: if (consume && regEofc != '0) state <= needOut ? ExtractTail : ExtractIdle;
        default:     if (!payStop) state <= ExtractIdle;
      endcase
`ifdef SMI_HEADER_EXTRACT_RUNT_CHECK_EN
      runtDetect <= consume && runtDrop && state == ExtractIdle;
`endif
    end
  end

`ifndef SMI_HEADER_EXTRACT_RUNT_CHECK_EN
  assign runtDetect = 1'b0;
`endif

  // input stage data, carried payload bytes and the eofc that sends a frame through the tail state
  always_ff @(posedge clk) begin
    if (!smiInStop) begin
      regEofc <= smiInEofc & EofcMask;
      regData <= smiInData;
    end
    if (consume) carry <= regData[FlitWidth*8-1:HeadWidth*8];
    if (consume && state == ExtractCopy) storedEofc <= regEofc;
  end

  smi_skid_buffer #(.Width(HeadWidth*8)) headerBuf (
    .clk      (clk),
    .arst_n   (arst_n),
    .inReady  (hdrPush),
    .inData   (hdrData),
    .inStop   (hdrStop),
    .outReady (headerReady),
    .outData  (headerData),
    .outStop  (headerStop)
  );

  smi_skid_buffer #(.Width((FlitWidth+1)*8)) payloadBuf (
    .clk      (clk),
    .arst_n   (arst_n),
    .inReady  (outPush),
    .inData   ({payEofc, payData}),
    .inStop   (payStop),
    .outReady (smiOutReady),
    .outData  (payOut),
    .outStop  (smiOutStop)
  );

endmodule

// File: tb/tb_smi_header_extract_pf1.sv
// tb_smi_header_extract_pf1: directed frame table plus reset/back-to-back sequence for the header extractor
module tb_smi_header_extract_pf1;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         smiInReady = 1'b0;
  logic [7:0]   smiInEofc = '0;
  logic [127:0] smiInData = '0;
  logic         smiInStop;
  logic         headerReady;
  logic [31:0]  headerData;
  logic         headerStop = 1'b0;
  logic         smiOutReady;
  logic [7:0]   smiOutEofc;
  logic [127:0] smiOutData;
  logic         smiOutStop = 1'b0;
  logic         runtDetect;

  int checks = 0;
  int errors = 0;
  int runtCount = 0;
  int inStopCount = 0;
  logic [31:0]  hdrQ[$];
  logic [135:0] payQ[$];

  typedef struct {
    string       name;
    int          nFlits;
    logic [7:0]  lastEofc;
    logic [31:0] hdrIn;
    logic [7:0]  seed;
    int          nHdr;
    logic [31:0] hdrExp;
    int          nPay;
    int          runts;
    int          outAt;
    int          hdrAt;
    int          pe [5];
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  smi_header_extract_pf1 #(.FlitWidth(16), .HeadWidth(4)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .smiInReady  (smiInReady),
    .smiInEofc   (smiInEofc),
    .smiInData   (smiInData),
    .smiInStop   (smiInStop),
    .headerReady (headerReady),
    .headerData  (headerData),
    .headerStop  (headerStop),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (smiOutStop),
    .runtDetect  (runtDetect)
  );

  always @(negedge clk) begin
    if (arst_n && headerReady && !headerStop) hdrQ.push_back(headerData);
    if (arst_n && smiOutReady && !smiOutStop) payQ.push_back({smiOutEofc, smiOutData});
    if (runtDetect) runtCount++;
    if (smiInStop) inStopCount++;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int n, input logic [7:0] e, input logic [31:0] hin,
                              input logic [7:0] seed, input int nHdr, input logic [31:0] hexp, input int nPay,
                              input int runts, input int outAt, input int hdrAt,
                              input int q0, input int q1, input int q2, input int q3, input int q4);
    vec_t v;
    v.name = name; v.nFlits = n; v.lastEofc = e; v.hdrIn = hin; v.seed = seed;
    v.nHdr = nHdr; v.hdrExp = hexp; v.nPay = nPay; v.runts = runts; v.outAt = outAt; v.hdrAt = hdrAt;
    v.pe[0] = q0; v.pe[1] = q1; v.pe[2] = q2; v.pe[3] = q3; v.pe[4] = q4;
    return v;
  endfunction

  function automatic logic [7:0] fb(input vec_t v, input int j);
    return j < 4 ? v.hdrIn[j*8+:8] : 8'(int'(v.seed) + j);
  endfunction

  task automatic pushFlit(input logic [127:0] d, input logic [7:0] e);
    int n = 0;
    smiInReady = 1'b1;
    smiInData  = d;
    smiInEofc  = e;
    @(negedge clk);
    while (smiInStop && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inStopTimeout", 128'(smiInStop), 128'(0));
    @(posedge clk);
    #1;
    smiInReady = 1'b0;
  endtask

  task automatic sendFrame(input vec_t v);
    logic [127:0] d;
    for (int k = 0; k < v.nFlits; k++) begin
      for (int i = 0; i < 16; i++) d[i*8+:8] = fb(v, 16*k + i);
      pushFlit(d, k == v.nFlits - 1 ? v.lastEofc : 8'd0);
    end
  endtask

  task automatic stallOut(input int at);
    repeat (at) @(posedge clk);
    #1 smiOutStop = 1'b1;
    repeat (5) @(posedge clk);
    #1 smiOutStop = 1'b0;
  endtask

  task automatic stallHdr(input int at);
    repeat (at) @(posedge clk);
    #1 headerStop = 1'b1;
    repeat (5) @(posedge clk);
    #1 headerStop = 1'b0;
  endtask

  task automatic checkOutputs(input vec_t v, input int h0, input int p0);
    int total = 16 * (v.nFlits - 1) + int'(v.lastEofc);
    int gotPay = payQ.size() - p0;
    logic [127:0] exp;
    check($sformatf("%s.hdrCount", v.name), 128'(hdrQ.size() - h0), 128'(v.nHdr));
    if (v.nHdr > 0 && hdrQ.size() > h0) check($sformatf("%s.hdr", v.name), 128'(hdrQ[h0]), 128'(v.hdrExp));
    check($sformatf("%s.payCount", v.name), 128'(gotPay), 128'(v.nPay));
    for (int k = 0; k < v.nPay && k < gotPay; k++) begin
      for (int i = 0; i < 16; i++) exp[i*8+:8] = (4 + 16*k + i) < total ? fb(v, 4 + 16*k + i) : 8'h00;
      check($sformatf("%s.pay%0d.eofc", v.name, k), 128'(payQ[p0+k][135:128]), 128'(v.pe[k]));
      check($sformatf("%s.pay%0d.data", v.name, k), payQ[p0+k][127:0], exp);
    end
  endtask

  task automatic runVec(input vec_t v);
    int h0 = hdrQ.size();
    int p0 = payQ.size();
    int r0 = runtCount;
    int s0 = inStopCount;
    fork
      sendFrame(v);
      if (v.outAt >= 0) stallOut(v.outAt);
      if (v.hdrAt >= 0) stallHdr(v.hdrAt);
    join
    repeat (15) @(negedge clk);
    checkOutputs(v, h0, p0);
    check($sformatf("%s.runts", v.name), 128'(runtCount - r0), 128'(v.runts));
    if (v.outAt >= 0) check($sformatf("%s.inStopSeen", v.name), 128'(inStopCount - s0 > 0), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t va, vb;
    int h0, p0;
    vecs.push_back(mk("single12", 1, 8'd12, 32'hDEADBEEF, 8'h10, 1, 32'hDEADBEEF, 1, 0, -1, -1, 8, 0, 0, 0, 0));
    vecs.push_back(mk("three10", 3, 8'd10, 32'hA1A2A3A4, 8'h20, 1, 32'hA1A2A3A4, 3, 0, -1, -1, 0, 0, 6, 0, 0));
    vecs.push_back(mk("two3", 2, 8'd3, 32'h0BADF00D, 8'h40, 1, 32'h0BADF00D, 1, 0, -1, -1, 15, 0, 0, 0, 0));
    vecs.push_back(mk("hdrOnly4", 1, 8'd4, 32'hCAFEBABE, 8'h50, 1, 32'hCAFEBABE, 0, 0, -1, -1, 0, 0, 0, 0, 0));
`ifdef SMI_HEADER_EXTRACT_RUNT_CHECK_EN
    vecs.push_back(mk("runt2", 1, 8'd2, 32'h11223344, 8'h60, 0, 32'h00003344, 0, 1, -1, -1, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk("runt2", 1, 8'd2, 32'h11223344, 8'h60, 1, 32'h00003344, 0, 0, -1, -1, 0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk("two16", 2, 8'd16, 32'h01020304, 8'h70, 1, 32'h01020304, 2, 0, -1, -1, 0, 12, 0, 0, 0));
    vecs.push_back(mk("single16", 1, 8'd16, 32'h89ABCDEF, 8'h80, 1, 32'h89ABCDEF, 1, 0, -1, -1, 12, 0, 0, 0, 0));
    vecs.push_back(mk("two4", 2, 8'd4, 32'h13579BDF, 8'h90, 1, 32'h13579BDF, 1, 0, -1, -1, 16, 0, 0, 0, 0));
    vecs.push_back(mk("single5", 1, 8'd5, 32'h2468ACE0, 8'hA0, 1, 32'h2468ACE0, 1, 0, -1, -1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("outStall", 5, 8'd7, 32'hFEEDFACE, 8'hB0, 1, 32'hFEEDFACE, 5, 0, 3, -1, 0, 0, 0, 0, 3));
    vecs.push_back(mk("hdrStall", 2, 8'd8, 32'h0F1E2D3C, 8'hC0, 1, 32'h0F1E2D3C, 2, 0, -1, 0, 0, 4, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("rst.headerReady", 128'(headerReady), 128'(0));
    check("rst.smiOutReady", 128'(smiOutReady), 128'(0));
    check("rst.smiInStop", 128'(smiInStop), 128'(0));
    check("rst.runtDetect", 128'(runtDetect), 128'(0));
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[n]) runVec(vecs[n]);

    va = mk("b2bA", 1, 8'd12, 32'h55667788, 8'hD0, 1, 32'h55667788, 1, 0, -1, -1, 8, 0, 0, 0, 0);
    vb = mk("b2bB", 3, 8'd10, 32'h99AABBCC, 8'hE0, 1, 32'h99AABBCC, 3, 0, -1, -1, 0, 0, 6, 0, 0);
    h0 = hdrQ.size();
    p0 = payQ.size();
    sendFrame(va);
    pushFlit({16{8'h33}}, 8'd0);
    pushFlit({16{8'h44}}, 8'd0);
    check("b2b.hdrCount", 128'(hdrQ.size() - h0), 128'(1));
    if (hdrQ.size() > h0) check("b2b.hdr", 128'(hdrQ[h0]), 128'(32'h55667788));
    check("b2b.payCount", 128'(payQ.size() - p0), 128'(1));
    if (payQ.size() > p0) check("b2b.payEofc", 128'(payQ[p0][135:128]), 128'(8));
    check("b2b.hdr2Pending", 128'(headerReady), 128'(1));
    arst_n = 1'b0;
    #1;
    check("midRst.headerReady", 128'(headerReady), 128'(0));
    check("midRst.smiOutReady", 128'(smiOutReady), 128'(0));
    check("midRst.smiInStop", 128'(smiInStop), 128'(0));
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    runVec(vb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
